// File: rtl/axi_pkg.sv
// Shared AXI definitions: response codes and the write-generator state type.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned COUNT_BITS = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_RESP
    } wr_state_e;

endpackage

// File: rtl/axi_write_gen.sv
// AXI write initiator: drains a valid/ready word stream into consecutive
// addresses using single-beat writes with one transaction outstanding.
module axi_write_gen
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 17,
    parameter int unsigned DATA_BITS = 64,
    parameter int unsigned STRB_BITS = DATA_BITS / 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_BITS-1:0]  start_addr,
    input  logic [COUNT_BITS-1:0] start_count,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_BITS-1:0]  in_data,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [ADDR_BITS-1:0]  axi_awaddr,
    output logic                  axi_wvalid,
    input  logic                  axi_wready,
    output logic [DATA_BITS-1:0]  axi_wdata,
    output logic [STRB_BITS-1:0]  axi_wstrb,
    input  logic                  axi_bvalid,
    output logic                  axi_bready,
    input  logic [1:0]            axi_bresp
);

    localparam logic [ADDR_BITS-1:0] ADDR_STEP = ADDR_BITS'(STRB_BITS);
    localparam logic [ADDR_BITS-1:0] ADDR_MASK = ~ADDR_BITS'(STRB_BITS - 1);

    wr_state_e             state;
    logic [COUNT_BITS-1:0] remaining;
    logic                  aw_ok_c;
    logic                  w_ok_c;

    // A channel is finished once its valid has dropped or is handshaking now.
    assign aw_ok_c   = !axi_awvalid || axi_awready;
    assign w_ok_c    = !axi_wvalid  || axi_wready;
    assign axi_wstrb = '1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            remaining   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            in_ready    <= 1'b0;
            axi_awvalid <= 1'b0;
            axi_awaddr  <= '0;
            axi_wvalid  <= 1'b0;
            axi_wdata   <= '0;
            axi_bready  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        error <= 1'b0;
                        if (start_count != '0) begin
                            axi_awaddr <= start_addr & ADDR_MASK;
                            remaining  <= start_count;
                            busy       <= 1'b1;
                            in_ready   <= 1'b1;
                            state      <= ST_LOAD;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        in_ready    <= 1'b0;
                        axi_wdata   <= in_data;
                        axi_awvalid <= 1'b1;
                        axi_wvalid  <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (axi_awready) axi_awvalid <= 1'b0;
                    if (axi_wready)  axi_wvalid  <= 1'b0;
                    if (aw_ok_c && w_ok_c) begin
                        axi_bready <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (axi_bvalid) begin
                        axi_bready <= 1'b0;
                        if (axi_bresp != RESP_OKAY) error <= 1'b1;
                        remaining  <= remaining - COUNT_BITS'(1);
                        axi_awaddr <= axi_awaddr + ADDR_STEP;
                        if (remaining == COUNT_BITS'(1)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= ST_LOAD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_gen.sv
// Directed bench for axi_write_gen: an AXI write responder and stream source
// with per-job delays, plus a table of jobs and hand-written corner sequences.
module tb_axi_write_gen;

    localparam int unsigned AB = 17;
    localparam int unsigned DB = 64;
    localparam int unsigned SB = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AB-1:0] start_addr;
    logic [15:0]   start_count;
    logic          busy, done, error;
    logic          in_valid, in_ready;
    logic [DB-1:0] in_data;
    logic          axi_awvalid, axi_awready;
    logic [AB-1:0] axi_awaddr;
    logic          axi_wvalid, axi_wready;
    logic [DB-1:0] axi_wdata;
    logic [SB-1:0] axi_wstrb;
    logic          axi_bvalid, axi_bready;
    logic [1:0]    axi_bresp;

    axi_write_gen #(.ADDR_BITS(AB), .DATA_BITS(DB), .STRB_BITS(SB)) dut (
        .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
        .start_count(start_count), .busy(busy), .done(done), .error(error),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_bresp(axi_bresp)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AB-1:0] addr;
        int            count;
        logic [DB-1:0] base;
        int            aw_dly;
        int            w_dly;
        int            stall;
        int            err_beat;
        logic [AB-1:0] exp_addr0;
        logic [AB-1:0] exp_last;
        logic          exp_err;
    } vec_t;

    vec_t vecs[7];

    int checks   = 0;
    int failures = 0;

    // responder / stream configuration and observation state
    int            cfg_aw_dly, cfg_w_dly, cfg_stall, cfg_err_beat, cfg_count;
    logic [DB-1:0] cfg_base;
    logic          s_active, in_fire, b_fire, aw_hold, w_hold;
    int            s_idx, s_wait, aw_cnt, w_cnt, aw_n, w_n, b_n, bhs;
    int            viol, strb_bad, done_cnt, mem_wr;
    logic [AB-1:0] aw_prev;
    logic [DB-1:0] w_prev;
    logic [AB-1:0] cap_addr[$];
    logic [DB-1:0] cap_data[$];
    logic [DB-1:0] mem[logic [AB-1:0]];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_bench();
        s_active = 1'b0; in_fire = 1'b0; b_fire = 1'b0; aw_hold = 1'b0; w_hold = 1'b0;
        s_idx = 0; s_wait = 0; aw_cnt = 0; w_cnt = 0; aw_n = 0; w_n = 0; b_n = 0;
        bhs = 0; viol = 0; strb_bad = 0; done_cnt = 0; mem_wr = 0;
        in_valid = 1'b0; in_data = '0;
        axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
        cap_addr.delete(); cap_data.delete(); mem.delete();
    endtask

    // Responder and stream source: ready/valid decisions made on the falling
    // edge, so a handshake is recorded when it is committed for the next rise.
    always @(negedge clock) begin
        if (!reset) begin
            if (b_fire) begin
                axi_bvalid = 1'b0;
                b_fire     = 1'b0;
            end else begin
                if (!axi_bvalid && aw_n > b_n && w_n > b_n) begin
                    axi_bvalid = 1'b1;
                    axi_bresp  = (b_n == cfg_err_beat) ? 2'b10 : 2'b00;
                    b_n++;
                end
                if (axi_bvalid && axi_bready) begin
                    b_fire = 1'b1;
                    bhs++;
                end
            end

            if (in_fire) begin
                in_valid = 1'b0;
                in_fire  = 1'b0;
                s_idx++;
                s_wait   = 0;
            end
            if (s_active && !in_valid && s_idx < cfg_count) begin
                if (s_idx == 0 || s_wait >= cfg_stall) begin
                    in_valid = 1'b1;
                    in_data  = cfg_base + DB'(s_idx);
                end else begin
                    s_wait++;
                end
            end
            if (in_valid && in_ready) in_fire = 1'b1;

            if ((axi_awvalid && s_idx <= aw_n) || (axi_wvalid && s_idx <= w_n)) viol++;

            if (aw_hold && (!axi_awvalid || axi_awaddr != aw_prev)) viol++;
            aw_hold = 1'b0;
            if (axi_awvalid) begin
                if (aw_cnt >= cfg_aw_dly) begin
                    axi_awready = 1'b1;
                    cap_addr.push_back(axi_awaddr);
                    aw_n++;
                    aw_cnt = 0;
                end else begin
                    axi_awready = 1'b0;
                    aw_cnt++;
                    aw_hold = 1'b1;
                    aw_prev = axi_awaddr;
                end
            end else begin
                axi_awready = 1'b0;
                aw_cnt = 0;
            end

            if (w_hold && (!axi_wvalid || axi_wdata != w_prev)) viol++;
            w_hold = 1'b0;
            if (axi_wvalid) begin
                if (w_cnt >= cfg_w_dly) begin
                    axi_wready = 1'b1;
                    if (axi_wstrb != 8'hFF) strb_bad++;
                    cap_data.push_back(axi_wdata);
                    w_n++;
                    w_cnt = 0;
                end else begin
                    axi_wready = 1'b0;
                    w_cnt++;
                    w_hold = 1'b1;
                    w_prev = axi_wdata;
                end
            end else begin
                axi_wready = 1'b0;
                w_cnt = 0;
            end

            if (cap_addr.size() > mem_wr && cap_data.size() > mem_wr) begin
                mem[cap_addr[mem_wr]] = cap_data[mem_wr];
                mem_wr++;
            end

            if (done) done_cnt++;
        end
    end

    task automatic pulse_start(input logic [AB-1:0] a, input int n);
        @(negedge clock);
        start       = 1'b1;
        start_addr  = a;
        start_count = 16'(n);
        @(negedge clock);
        start       = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int t;
        t = 0;
        while (done_cnt == 0 && t < 400) begin
            @(negedge clock);
            t++;
        end
        if (done_cnt == 0) chk({nm, "_timeout"}, 64'd0, 64'd1);
        repeat (3) @(negedge clock);
    endtask

    task automatic check_job(input string nm, input vec_t v);
        logic [AB-1:0] ea;
        chk({nm, "_aw_count"}, 64'(cap_addr.size()), 64'(v.count));
        chk({nm, "_w_count"},  64'(cap_data.size()), 64'(v.count));
        for (int i = 0; i < v.count && i < cap_addr.size() && i < cap_data.size(); i++) begin
            ea = v.exp_addr0 + AB'(i * int'(SB));
            chk($sformatf("%s_addr%0d", nm, i), 64'(cap_addr[i]), 64'(ea));
            chk($sformatf("%s_data%0d", nm, i), cap_data[i], v.base + DB'(i));
            chk($sformatf("%s_mem_has%0d", nm, i), 64'(mem.exists(ea)), 64'd1);
            if (mem.exists(ea)) chk($sformatf("%s_mem%0d", nm, i), mem[ea], v.base + DB'(i));
        end
        if (cap_addr.size() == v.count) chk({nm, "_last_addr"}, 64'(cap_addr[v.count-1]), 64'(v.exp_last));
        chk({nm, "_bhs"},      64'(bhs), 64'(v.count));
        chk({nm, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({nm, "_error"},    64'(error), 64'(v.exp_err));
        chk({nm, "_busy_end"}, 64'(busy), 64'd0);
        chk({nm, "_viol"},     64'(viol), 64'd0);
        chk({nm, "_strb"},     64'(strb_bad), 64'd0);
    endtask

    task automatic setup_job(input vec_t v);
        clear_bench();
        cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly; cfg_stall = v.stall;
        cfg_err_beat = v.err_beat; cfg_count = v.count; cfg_base = v.base;
        s_active = 1'b1;
    endtask

    task automatic run_job(input string nm, input vec_t v);
        setup_job(v);
        pulse_start(v.addr, v.count);
        chk({nm, "_busy"},      64'(busy), 64'd1);
        chk({nm, "_err_clear"}, 64'(error), 64'd0);
        wait_done(nm);
        check_job(nm, v);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_busy"},    64'(busy), 64'd0);
        chk({nm, "_done"},    64'(done), 64'd0);
        chk({nm, "_error"},   64'(error), 64'd0);
        chk({nm, "_inrdy"},   64'(in_ready), 64'd0);
        chk({nm, "_awvalid"}, 64'(axi_awvalid), 64'd0);
        chk({nm, "_wvalid"},  64'(axi_wvalid), 64'd0);
        chk({nm, "_bready"},  64'(axi_bready), 64'd0);
        chk({nm, "_awaddr"},  64'(axi_awaddr), 64'd0);
        chk({nm, "_wdata"},   axi_wdata, 64'd0);
    endtask

    initial begin
        vec_t v;
        int   t;
        //          addr      cnt base     awd wd stl err  exp0      last      err
        vecs[0] = '{17'h00100, 3, 64'hA,   0,  0, 0,  -1, 17'h00100, 17'h00110, 1'b0};
        vecs[1] = '{17'h00200, 2, 64'h20,  3,  1, 0,  -1, 17'h00200, 17'h00208, 1'b0};
        vecs[2] = '{17'h00300, 2, 64'h30,  1,  3, 0,  -1, 17'h00300, 17'h00308, 1'b0};
        vecs[3] = '{17'h00400, 2, 64'h40,  0,  0, 5,  -1, 17'h00400, 17'h00408, 1'b0};
        vecs[4] = '{17'h00500, 3, 64'h50,  0,  0, 0,   1, 17'h00500, 17'h00510, 1'b1};
        vecs[5] = '{17'h1FFF8, 2, 64'h60,  0,  0, 0,  -1, 17'h1FFF8, 17'h00000, 1'b0};
        vecs[6] = '{17'h00605, 1, 64'h66,  2,  0, 0,  -1, 17'h00600, 17'h00600, 1'b0};

        reset = 1'b1; start = 1'b0; start_addr = '0; start_count = '0;
        cfg_aw_dly = 0; cfg_w_dly = 0; cfg_stall = 0; cfg_err_beat = -1;
        cfg_count = 0; cfg_base = '0; aw_prev = '0; w_prev = '0;
        clear_bench();
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_job($sformatf("vec%0d", i), vecs[i]);

        // zero-length job: immediate done, no traffic
        clear_bench();
        pulse_start(17'h00900, 0);
        chk("zero_done",  64'(done), 64'd1);
        chk("zero_busy",  64'(busy), 64'd0);
        @(negedge clock);
        chk("zero_done_low", 64'(done), 64'd0);
        repeat (3) @(negedge clock);
        chk("zero_aw", 64'(aw_n), 64'd0);

        // start while busy is ignored
        v = '{17'h00700, 2, 64'h70, 1, 0, 0, -1, 17'h00700, 17'h00708, 1'b0};
        setup_job(v);
        pulse_start(v.addr, v.count);
        repeat (2) @(negedge clock);
        start = 1'b1; start_addr = 17'h00000; start_count = 16'd5;
        @(negedge clock);
        start = 1'b0;
        wait_done("busy_start");
        check_job("busy_start", v);

        // reset while AW is held waiting for ready
        v = '{17'h00800, 1, 64'h80, 20, 20, 0, -1, 17'h00800, 17'h00800, 1'b0};
        setup_job(v);
        pulse_start(v.addr, v.count);
        t = 0;
        while (!axi_awvalid && t < 50) begin
            @(negedge clock);
            t++;
        end
        chk("rst_mid_awvalid_seen", 64'(axi_awvalid), 64'd1);
        reset = 1'b1;
        clear_bench();
        @(negedge clock);
        check_all_zero("rst_mid");
        reset = 1'b0;
        run_job("after_rst", vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
